// File: rtl/iob_sync_asym_fifo_r_big.sv
// ============================================================================
// iob_sync_asym_fifo_r_big : single-clock FIFO controller for an external
// asymmetric RAM (narrow write port, wide registered read port).
// Optional macro IOB_ASYM_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_sync_asym_fifo_r_big #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 32,
  parameter int ADDR_W   = 7,
  // Derived; not meant to be overridden.
  parameter int L2R      = $clog2(R_DATA_W / W_DATA_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [W_DATA_W-1:0]     w_data,
  output logic                    w_full,
  input  logic                    r_en,
  output logic [R_DATA_W-1:0]     r_data,
  output logic                    r_empty,
  output logic [ADDR_W:0]         level,
  output logic                    ext_mem_w_en,
  output logic [ADDR_W-1:0]       ext_mem_w_addr,
  output logic [W_DATA_W-1:0]     ext_mem_w_data,
  output logic                    ext_mem_r_en,
  output logic [ADDR_W-L2R-1:0]   ext_mem_r_addr,
  input  logic [R_DATA_W-1:0]     ext_mem_r_data
`ifdef IOB_ASYM_FIFO_ERR_FLAGS_EN
  ,
  output logic                    w_overflow,
  output logic                    r_underflow
`endif
);

  localparam int RATIO = R_DATA_W / W_DATA_W;
  localparam logic [ADDR_W:0] RATIO_V = (ADDR_W + 1)'(RATIO);
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_V   = (ADDR_W + 1)'(1);

  logic [ADDR_W:0] w_ptr_q, w_ptr_d;
  logic [ADDR_W:0] r_ptr_q, r_ptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            wa;
  logic            ra;

  assign w_full  = (level_q == DEPTH_V);
  assign r_empty = (level_q < RATIO_V);
  assign level   = level_q;

  // Enables are forced low while in reset so the RAM never sees a stray access.
  assign wa = w_en & ~w_full & ~rst;
  assign ra = r_en & ~r_empty & ~rst;

  assign ext_mem_w_en   = wa;
  assign ext_mem_w_addr = w_ptr_q[ADDR_W-1:0];
  assign ext_mem_w_data = w_data;
  assign ext_mem_r_en   = ra;
  assign ext_mem_r_addr = r_ptr_q[ADDR_W-1:L2R];

  // The RAM already registers its output, so read data passes straight through.
  assign r_data = ext_mem_r_data;

  // Pointer MSBs only disambiguate wrap; low read-pointer bits are always zero.
  logic unused_ptr_bits;
  assign unused_ptr_bits = ^{w_ptr_q[ADDR_W], r_ptr_q[ADDR_W], r_ptr_q[L2R-1:0]};

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (wa) w_ptr_d = w_ptr_q + ONE_V;
    if (ra) r_ptr_d = r_ptr_q + RATIO_V;
    level_d = level_q + {{ADDR_W{1'b0}}, wa} - (ra ? RATIO_V : {(ADDR_W + 1){1'b0}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
    end
  end

`ifdef IOB_ASYM_FIFO_ERR_FLAGS_EN
  logic w_overflow_q, w_overflow_d;
  logic r_underflow_q, r_underflow_d;

  always_comb begin
    w_overflow_d  = w_overflow_q | (w_en & w_full);
    r_underflow_d = r_underflow_q | (r_en & r_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_overflow_q  <= 1'b0;
      r_underflow_q <= 1'b0;
    end else begin
      w_overflow_q  <= w_overflow_d;
      r_underflow_q <= r_underflow_d;
    end
  end

  assign w_overflow  = w_overflow_q;
  assign r_underflow = r_underflow_q;
`endif

endmodule

`default_nettype wire
